sha1_core: RTL and testbench



---
 rtl/sha1_core.sv | 173 +++++++++++++++++
 tb/tb_sha1_core.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/sha1_core.sv
// Iterative SHA-1 compression engine: one pre-padded 512-bit chunk per command,
// one round per clock, chaining state held across chunks via init/next.
module sha1_core (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic         next,
  input  logic [511:0] chunk,
  output logic         ready,
  output logic [159:0] out_digest,
  output logic         out_valid
);

  localparam logic [31:0] IV0 = 32'h67452301;
  localparam logic [31:0] IV1 = 32'hEFCDAB89;
  localparam logic [31:0] IV2 = 32'h98BADCFE;
  localparam logic [31:0] IV3 = 32'h10325476;
  localparam logic [31:0] IV4 = 32'hC3D2E1F0;

  localparam logic [31:0] K0 = 32'h5A827999;
  localparam logic [31:0] K1 = 32'h6ED9EBA1;
  localparam logic [31:0] K2 = 32'h8F1BBCDC;
  localparam logic [31:0] K3 = 32'hCA62C1D6;

  localparam logic [6:0] LAST_ROUND = 7'd79;

  typedef enum logic [1:0] {
    IDLE,
    ROUNDS,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] h0, h1, h2, h3, h4;
  logic [31:0] a, b, c, d, e;
  logic [31:0] w [16];
  logic [6:0]  round;

  logic        start_init;
  logic        start_next;
  logic        start;

  logic [31:0] f_val;
  logic [31:0] k_val;
  logic [31:0] t_val;
  logic [31:0] w_new;

  // ready is only high in IDLE, so it doubles as the command acceptance gate
  assign start_init = ready & init;
  assign start_next = ready & next & ~init;
  assign start      = start_init | start_next;

  assign out_digest = {h0, h1, h2, h3, h4};

  always_comb begin
    f_val = 32'h0;
    k_val = 32'h0;
    if (round < 7'd20) begin
      f_val = (b & c) | (~b & d);
      k_val = K0;
    end else if (round < 7'd40) begin
      f_val = b ^ c ^ d;
      k_val = K1;
    end else if (round < 7'd60) begin
      f_val = (b & c) | (b & d) | (c & d);
      k_val = K2;
    end else begin
      f_val = b ^ c ^ d;
      k_val = K3;
    end
    t_val = {a[26:0], a[31:27]} + f_val + e + k_val + w[0];
    // w[k] holds W_{t+k}, so taps 13/8/2/0 give W_{t+16}
    w_new = w[13] ^ w[8] ^ w[2] ^ w[0];
    w_new = {w_new[30:0], w_new[31]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ROUNDS;
      ROUNDS:  if (round == LAST_ROUND) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h0        <= 32'h0;
      h1        <= 32'h0;
      h2        <= 32'h0;
      h3        <= 32'h0;
      h4        <= 32'h0;
      a         <= 32'h0;
      b         <= 32'h0;
      c         <= 32'h0;
      d         <= 32'h0;
      e         <= 32'h0;
      for (int i = 0; i < 16; i++) begin
        w[i] <= 32'h0;
      end
      round     <= 7'd0;
      ready     <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (start_init) begin
              h0 <= IV0;
              h1 <= IV1;
              h2 <= IV2;
              h3 <= IV3;
              h4 <= IV4;
              a  <= IV0;
              b  <= IV1;
              c  <= IV2;
              d  <= IV3;
              e  <= IV4;
            end else begin
              a <= h0;
              b <= h1;
              c <= h2;
              d <= h3;
              e <= h4;
            end
            for (int i = 0; i < 16; i++) begin
              w[i] <= chunk[511 - 32*i -: 32];
            end
            round     <= 7'd0;
            ready     <= 1'b0;
            out_valid <= 1'b0;
          end
        end
        ROUNDS: begin
          e <= d;
          d <= c;
          c <= {b[1:0], b[31:2]};
          b <= a;
          a <= t_val;
          for (int i = 0; i < 15; i++) begin
            w[i] <= w[i+1];
          end
          w[15] <= w_new;
          round <= round + 7'd1;
        end
        DONE: begin
          h0        <= h0 + a;
          h1        <= h1 + b;
          h2        <= h2 + c;
          h3        <= h3 + d;
          h4        <= h4 + e;
          ready     <= 1'b1;
          out_valid <= 1'b1;
        end
        default: begin
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_core.sv
// Directed bench for sha1_core: known FIPS vectors, busy-time command rejection,
// mid-operation reset and init/next priority.
module tb_sha1_core;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         init;
  logic         next;
  logic [511:0] chunk;
  logic         ready;
  logic [159:0] out_digest;
  logic         out_valid;

  int checks = 0;
  int errors = 0;
  int cycles;

  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] P1_BLK  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] P2_BLK  = {480'h0, 32'h000001C0};

  localparam logic [159:0] ABC_DIG = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
  localparam logic [159:0] P1_DIG  = 160'hf4286818c37b27ae0408f581846771484a566572;
  localparam logic [159:0] P2_DIG  = 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1;

  always #5 clk = ~clk;

  sha1_core dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .init       (init),
    .next       (next),
    .chunk      (chunk),
    .ready      (ready),
    .out_digest (out_digest),
    .out_valid  (out_valid)
  );

  task automatic check_output(input string tag, input logic [159:0] observed,
                              input logic [159:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      $error("[TB] %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one command for a single edge, then scramble chunk to prove it was captured
  task automatic apply_stimulus(input logic do_init, input logic do_next,
                                input logic [511:0] blk);
    init  = do_init;
    next  = do_next;
    chunk = blk;
    step();
    init = 1'b0;
    next = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chunk[32*i +: 32] = $urandom();
    end
  endtask

  task automatic wait_ready(input int start, output int count);
    count = start;
    while (ready !== 1'b1 && count < 300) begin
      step();
      count++;
    end
  endtask

  task automatic run_block(input string tag, input logic do_init, input logic do_next,
                           input logic [511:0] blk, input logic [159:0] digest);
    int n;
    apply_stimulus(do_init, do_next, blk);
    check_output({tag, "_ready_low"}, 160'(ready), 160'd0);
    check_output({tag, "_valid_low"}, 160'(out_valid), 160'd0);
    wait_ready(0, n);
    check_output({tag, "_latency"}, 160'(n), 160'd81);
    check_output({tag, "_valid"}, 160'(out_valid), 160'd1);
    check_output({tag, "_digest"}, out_digest, digest);
  endtask

  initial begin
    reset_n = 1'b0;
    init    = 1'b0;
    next    = 1'b0;
    chunk   = '0;
    repeat (3) step();
    check_output("rst_ready", 160'(ready), 160'd1);
    check_output("rst_valid", 160'(out_valid), 160'd0);
    check_output("rst_digest", out_digest, 160'd0);
    reset_n = 1'b1;
    repeat (2) step();
    check_output("idle_ready", 160'(ready), 160'd1);

    $display("[TB] abc single block");
    run_block("abc", 1'b1, 1'b0, ABC_BLK, ABC_DIG);
    repeat (3) step();
    check_output("abc_hold_digest", out_digest, ABC_DIG);
    check_output("abc_hold_valid", 160'(out_valid), 160'd1);

    $display("[TB] two-block message");
    run_block("two_p1", 1'b1, 1'b0, P1_BLK, P1_DIG);
    repeat (7) step();
    check_output("two_idle_digest", out_digest, P1_DIG);
    run_block("two_p2", 1'b0, 1'b1, P2_BLK, P2_DIG);

    $display("[TB] commands while busy");
    apply_stimulus(1'b1, 1'b0, ABC_BLK);
    repeat (10) step();
    init  = 1'b1;
    next  = 1'b1;
    chunk = P2_BLK;
    step();
    init = 1'b0;
    next = 1'b0;
    check_output("busy_ready_low", 160'(ready), 160'd0);
    wait_ready(11, cycles);
    check_output("busy_latency", 160'(cycles), 160'd81);
    check_output("busy_digest", out_digest, ABC_DIG);

    $display("[TB] reset at round 40");
    apply_stimulus(1'b1, 1'b0, ABC_BLK);
    repeat (40) step();
    check_output("mid_ready_busy", 160'(ready), 160'd0);
    reset_n = 1'b0;
    #1;
    check_output("mid_rst_ready", 160'(ready), 160'd1);
    check_output("mid_rst_valid", 160'(out_valid), 160'd0);
    check_output("mid_rst_digest", out_digest, 160'd0);
    step();
    reset_n = 1'b1;
    step();
    run_block("after_rst", 1'b1, 1'b0, ABC_BLK, ABC_DIG);

    $display("[TB] init and next together");
    run_block("prior", 1'b1, 1'b0, P1_BLK, P1_DIG);
    run_block("init_wins", 1'b1, 1'b1, ABC_BLK, ABC_DIG);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
